// File: rtl/mtt_req_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ translation lookups into a single page-table walker,
// one outstanding walk at a time, with a walk timeout and flush abort.
module mtt_req_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int PADDR_W     = 56,
   parameter int ENTRY_W     = 64,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,

   input  logic [NUM_REQ-1:0]           req_valid_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   input  logic [NUM_REQ*PADDR_W-1:0]   req_paddr_i,
   input  logic [NUM_REQ*2-1:0]         req_access_i,

   output logic [NUM_REQ-1:0]           rsp_valid_o,
   output logic                         rsp_allow_o,
   output logic                         rsp_fault_o,
   output logic [3:0]                   rsp_format_err_o,
   output logic [ENTRY_W-1:0]           rsp_entry_o,
   output logic                         timeout_o,

   output logic                         ptw_enable_o,
   output logic                         ptw_addr_valid_o,
   output logic [PADDR_W-1:0]           ptw_paddr_o,
   output logic [1:0]                   ptw_access_o,
   output logic                         ptw_flush_o,

   input  logic                         ptw_busy_i,
   input  logic                         ptw_valid_i,
   input  logic                         ptw_allow_i,
   input  logic                         ptw_fault_i,
   input  logic [3:0]                   ptw_format_err_i,
   input  logic [ENTRY_W-1:0]           ptw_entry_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]     gnt_q, gnt_d;
   logic [PADDR_W-1:0]   paddr_q, paddr_d;
   logic [1:0]           access_q, access_d;
   logic [15:0]          cnt_q, cnt_d;

   logic                 ptw_enable_q, ptw_enable_d;
   logic                 addr_valid_q, addr_valid_d;
   logic                 ptw_flush_q, ptw_flush_d;
   logic                 timeout_q, timeout_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 allow_q, allow_d;
   logic                 fault_q, fault_d;
   logic [3:0]           fmt_q, fmt_d;
   logic [ENTRY_W-1:0]   entry_q, entry_d;

   logic [PTR_W-1:0]     arb_idx;
   logic                 arb_found;
   logic [PTR_W:0]       arb_sum;
   logic [PTR_W-1:0]     arb_cand;
   logic [PTR_W-1:0]     rr_next;
   logic                 handshake;
   logic                 walk_done;
   logic                 walk_timeout;
   logic                 rsp_fire;

   // The walker's busy flag carries no information this arbiter needs.
   logic                 unused_busy;
   assign unused_busy = ptw_busy_i;

   // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first set bit wins.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_sum   = '0;
      arb_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (arb_sum >= (PTR_W+1)'(NUM_REQ)) begin
            arb_sum = arb_sum - (PTR_W+1)'(NUM_REQ);
         end
         arb_cand = arb_sum[PTR_W-1:0];
         if (!arb_found && req_valid_i[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
   end

   assign rr_next   = ({1'b0, arb_idx} == (PTR_W+1)'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
   assign handshake = rst_ni && (state_q == IDLE) && !flush_i && arb_found;

   always_comb begin
      req_ready_o = '0;
      if (handshake) begin
         req_ready_o[arb_idx] = 1'b1;
      end
   end

   assign walk_done    = ptw_valid_i | ptw_fault_i | (|ptw_format_err_i);
   assign walk_timeout = !walk_done && (cnt_q == 16'(TIMEOUT_CYC - 1));

   // Next-state and next-output logic; every walker-facing strobe is registered so it
   // lines up with the state it belongs to.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_d        = gnt_q;
      paddr_d      = paddr_q;
      access_d     = access_q;
      cnt_d        = cnt_q;
      ptw_enable_d = 1'b0;
      addr_valid_d = 1'b0;
      ptw_flush_d  = 1'b0;
      timeout_d    = 1'b0;
      rsp_valid_d  = 1'b0;
      allow_d      = allow_q;
      fault_d      = fault_q;
      fmt_d        = fmt_q;
      entry_d      = entry_q;

      unique case (state_q)
         IDLE: begin
            if (handshake) begin
               gnt_d        = arb_idx;
               rr_ptr_d     = rr_next;
               paddr_d      = req_paddr_i[arb_idx*PADDR_W +: PADDR_W];
               access_d     = req_access_i[arb_idx*2 +: 2];
               ptw_enable_d = 1'b1;
               addr_valid_d = 1'b1;
               state_d      = ISSUE;
            end
         end

         ISSUE: begin
            cnt_d = '0;
            if (flush_i) begin
               ptw_flush_d = 1'b1;
               state_d     = IDLE;
            end else begin
               ptw_enable_d = 1'b1;
               state_d      = WAIT;
            end
         end

         WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (flush_i) begin
               ptw_flush_d = 1'b1;
               state_d     = IDLE;
            end else if (walk_done) begin
               allow_d     = ptw_allow_i & ptw_valid_i & ~ptw_fault_i;
               fault_d     = ptw_fault_i;
               fmt_d       = ptw_format_err_i;
               entry_d     = ptw_entry_i;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (walk_timeout) begin
               allow_d     = 1'b0;
               fault_d     = 1'b1;
               fmt_d       = '0;
               entry_d     = '0;
               timeout_d   = 1'b1;
               ptw_flush_d = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               ptw_enable_d = 1'b1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         gnt_q        <= '0;
         paddr_q      <= '0;
         access_q     <= '0;
         cnt_q        <= '0;
         ptw_enable_q <= 1'b0;
         addr_valid_q <= 1'b0;
         ptw_flush_q  <= 1'b0;
         timeout_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
         allow_q      <= 1'b0;
         fault_q      <= 1'b0;
         fmt_q        <= '0;
         entry_q      <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_q        <= gnt_d;
         paddr_q      <= paddr_d;
         access_q     <= access_d;
         cnt_q        <= cnt_d;
         ptw_enable_q <= ptw_enable_d;
         addr_valid_q <= addr_valid_d;
         ptw_flush_q  <= ptw_flush_d;
         timeout_q    <= timeout_d;
         rsp_valid_q  <= rsp_valid_d;
         allow_q      <= allow_d;
         fault_q      <= fault_d;
         fmt_q        <= fmt_d;
         entry_q      <= entry_d;
      end
   end

   // A flush landing in the RESP cycle cancels the response that cycle.
   assign rsp_fire = rsp_valid_q & ~flush_i;

   always_comb begin
      rsp_valid_o = '0;
      if (rsp_fire) begin
         rsp_valid_o[gnt_q] = 1'b1;
      end
   end

   assign rsp_allow_o      = rsp_fire & allow_q;
   assign rsp_fault_o      = rsp_fire & fault_q;
   assign rsp_format_err_o = rsp_fire ? fmt_q   : '0;
   assign rsp_entry_o      = rsp_fire ? entry_q : '0;
   assign timeout_o        = timeout_q;

   assign ptw_enable_o     = ptw_enable_q;
   assign ptw_addr_valid_o = addr_valid_q;
   assign ptw_paddr_o      = paddr_q;
   assign ptw_access_o     = access_q;
   assign ptw_flush_o      = ptw_flush_q;

endmodule

// File: doc/mtt_req_arbiter.md
MTT_REQ_ARBITER -- requirements
Module: mtt_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter PADDR_W, default 56, physical address width.
REQ-003 SHALL have parameter ENTRY_W, default 64, TLB entry width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, maximum walk cycles before forced fault (1..65535).
REQ-005 SHALL have port clk_i, input, 1, single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port flush_i, input, 1, abort the current walk and drop any pending grant.
REQ-008 SHALL have port req_valid_i, input, NUM_REQ, per-requester lookup request.
REQ-009 SHALL have port req_ready_o, output, NUM_REQ, per-requester request accept.
REQ-010 SHALL have port req_paddr_i, input, NUM_REQ*PADDR_W, packed addresses, requester i at bits [i*PADDR_W +: PADDR_W].
REQ-011 SHALL have port req_access_i, input, NUM_REQ*2, packed access types: 00 read, 01 write, 10 execute, 11 reserved.
REQ-012 SHALL have port rsp_valid_o, output, NUM_REQ, one-hot response strobe.
REQ-013 SHALL have ports rsp_allow_o (1), rsp_fault_o (1), rsp_format_err_o (4) and rsp_entry_o (ENTRY_W), all outputs, shared response payload.
REQ-014 SHALL have port timeout_o, output, 1, pulses when a walk is forcibly ended.
REQ-015 SHALL have outputs ptw_enable_o (1), ptw_addr_valid_o (1), ptw_paddr_o (PADDR_W), ptw_access_o (2) and ptw_flush_o (1), all driving the walker.
REQ-016 SHALL have inputs ptw_busy_i (1), ptw_valid_i (1), ptw_allow_i (1), ptw_fault_i (1), ptw_format_err_i (4) and ptw_entry_i (ENTRY_W), all returned by the walker.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-018 SHALL, in IDLE, assert combinationally req_ready_o[g] for exactly the granted index g, chosen round-robin from pointer rr_ptr among set req_valid_i bits, when flush_i=0.
REQ-019 SHALL, on handshake (valid&ready), latch the paddr, access type and g, set rr_ptr=(g+1) mod NUM_REQ, and go to ISSUE.
REQ-020 SHALL, in ISSUE, drive ptw_enable_o=1 and ptw_addr_valid_o=1 for exactly one cycle with the latched paddr and access, then go to WAIT.
REQ-021 SHALL, in WAIT, hold ptw_enable_o=1 and ptw_addr_valid_o=0, and increment the 16-bit walk counter (cleared in ISSUE) each cycle.
REQ-022 SHALL define walk done in WAIT as ptw_valid_i | ptw_fault_i | (ptw_format_err_i!=0).
REQ-023 SHALL, on done, register allow=ptw_allow_i&ptw_valid_i&~ptw_fault_i, fault, format_err and entry, then go to RESP.
REQ-024 SHALL, if the counter reaches TIMEOUT_CYC without done, register allow=0, fault=1, format_err=0 and entry=0, pulse timeout_o and ptw_flush_o for one cycle, and go to RESP.
REQ-025 SHALL treat done and timeout in the same cycle as done (walker result wins, no timeout_o).
REQ-026 SHALL, in RESP, assert rsp_valid_o[g] for one cycle with the registered payload, then go to IDLE; responses have no backpressure.
REQ-027 SHALL hold the payload outputs at 0 whenever rsp_valid_o=0.
REQ-028 SHALL give latency as follows: handshake at cycle 0, ISSUE at 1, earliest done at 2, rsp_valid_o at cycle done+1.
REQ-029 SHALL, on flush_i in ISSUE, WAIT or RESP, return to IDLE next cycle, emit no response, and pulse ptw_flush_o if in ISSUE or WAIT; rr_ptr is kept.
REQ-030 SHALL, on flush_i in IDLE, accept no request that cycle.
REQ-031 SHALL accept no new request outside IDLE (one outstanding walk).
REQ-032 SHALL ignore walker inputs outside WAIT.
REQ-033 SHALL ignore reserved access type 11 and forward it unchanged.

Reset
REQ-034 SHALL, while rst_ni=0, force state IDLE, rr_ptr=0, counter 0, and all outputs 0, asynchronously.
REQ-035 SHALL, on reset assertion mid-walk, drop the walk with no response and no ptw_flush_o.

Verification
REQ-036 SHALL cover single request: req_valid_i=01, paddr 0x1000 read, walker valid+allow at cycle 2 -> rsp_valid_o=01 at cycle 3, allow=1.
REQ-037 SHALL cover contention: req_valid_i=11 held over two walks -> grants go 0 then 1, rr_ptr back at 0.
REQ-038 SHALL cover timeout: TIMEOUT_CYC=4, walker silent -> timeout_o and ptw_flush_o pulse, rsp fault=1, allow=0.
REQ-039 SHALL cover format error: ptw_format_err_i=3 in WAIT -> rsp_format_err_o=3, allow=0.
REQ-040 SHALL cover flush in WAIT: flush_i at cycle 3 -> ptw_flush_o pulses, no rsp_valid_o, IDLE at cycle 4.
REQ-041 SHALL cover reset mid-WAIT: rst_ni low -> all outputs 0 immediately, rr_ptr=0.
